// File: rtl/yolo_pkg.sv
// yolo_pkg: shared pixel-word geometry and streamer state type.
// Used by fmap_streamer and stream_skid.
package yolo_pkg;

  localparam int PIXEL_W     = 64;
  localparam int CH_PER_WORD = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } strm_state_e;

endpackage

// File: rtl/fmap_streamer_skid.sv
// stream_skid: 2-entry valid/ready buffer with bypass when empty.
// Upstream pushes unconditionally; the producer owns the slot budget.
module stream_skid
  import yolo_pkg::*;
#(
  parameter int DW = PIXEL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;

  assign w_byp   = (r_cnt == 2'd0);
  assign o_valid = !w_byp || i_valid;
  assign o_data  = !w_byp  ? r_mem[r_rp] :
                   i_valid ? i_data : '0;
  assign w_pop   = !w_byp && i_ready;
  // a beat shown in bypass but not taken is parked for the next cycle
  assign w_push  = i_valid && !(w_byp && i_ready);
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fmap_streamer.sv
// fmap_streamer: NHWC feature-map reader, 8 channels per beat.
// Define FMAP_STREAMER_PAD_EN for a 1-pixel zero border.
module fmap_streamer
  import yolo_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_DIM = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        in_channels,
  input  logic [15:0]        img_width,
  input  logic [15:0]        img_height,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [PIXEL_W-1:0] mem_rd_data,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               data_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int DW = $clog2(MAX_DIM + 3);
  localparam int GS = $clog2(CH_PER_WORD);
  localparam int GW = 16 - GS;

  strm_state_e       r_state;
  strm_state_e       w_next;
  logic [GW-1:0]     r_g;
  logic [GW-1:0]     r_gmax;
  logic [DW-1:0]     r_c;
  logic [DW-1:0]     r_cmax;
  logic [DW-1:0]     r_r;
  logic [DW-1:0]     r_rmax;
  logic [ADDR_W-1:0] r_addr;
  logic              r_vld_d;
  logic              r_done;

  logic [GW-1:0]      w_grp;
  logic               w_zero;
  logic [1:0]         w_cnt;
  logic [2:0]         w_occ;
  logic [2:0]         w_left;
  logic               w_xfer;
  logic               w_issue;
  logic               w_rd;
  logic               w_last_g;
  logic               w_last_c;
  logic               w_last;
  logic               w_final;
  logic [PIXEL_W-1:0] w_din;
  logic               w_unused;

  assign w_grp    = in_channels[15:GS];
  assign w_zero   = (w_grp == '0) || (img_width == '0) ||
                    (img_height == '0);
  assign w_unused = ^in_channels[GS-1:0];

  assign w_xfer  = data_valid && out_ready;
  assign w_occ   = {1'b0, w_cnt} + {2'b0, r_vld_d};
  assign w_left  = w_occ - {2'b0, w_xfer};
  // only issue when the beat already in flight still leaves a free slot
  assign w_issue = (r_state == ST_RUN) && (w_left <= 3'd1);

  assign w_last_g = (r_g == r_gmax);
  assign w_last_c = (r_c == r_cmax);
  assign w_last   = w_last_g && w_last_c && (r_r == r_rmax);
  assign w_final  = (r_state == ST_DRAIN) && w_xfer &&
                    (w_occ == 3'd1);

`ifdef FMAP_STREAMER_PAD_EN
  logic w_pad;
  logic r_pad_d;
  assign w_pad = (r_r == '0) || (r_r == r_rmax) ||
                 (r_c == '0) || (r_c == r_cmax);
  assign w_rd  = w_issue && !w_pad;
  assign w_din = r_pad_d ? '0 : mem_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_pad_d <= 1'b0;
    else        r_pad_d <= w_pad;
  end
`else
  assign w_rd  = w_issue;
  assign w_din = mem_rd_data;
`endif

  assign mem_rd_en   = w_rd;
  assign mem_rd_addr = r_addr;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start && !w_zero) w_next = ST_RUN;
      ST_RUN:   if (w_issue && w_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_final) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_gmax  <= '0;
      r_c     <= '0;
      r_cmax  <= '0;
      r_r     <= '0;
      r_rmax  <= '0;
      r_addr  <= '0;
      r_vld_d <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vld_d <= w_issue;
      r_done  <= w_final ||
                 ((r_state == ST_IDLE) && start && w_zero);
      if ((r_state == ST_IDLE) && start) begin
        r_g    <= '0;
        r_c    <= '0;
        r_r    <= '0;
        r_gmax <= w_grp - 1'b1;
        r_addr <= base_addr;
`ifdef FMAP_STREAMER_PAD_EN
        r_cmax <= img_width[DW-1:0] + 1'b1;
        r_rmax <= img_height[DW-1:0] + 1'b1;
`else
        r_cmax <= img_width[DW-1:0] - 1'b1;
        r_rmax <= img_height[DW-1:0] - 1'b1;
`endif
      end else if (w_issue) begin
        if (w_rd) r_addr <= r_addr + 1'b1;
        if (!w_last_g) begin
          r_g <= r_g + 1'b1;
        end else begin
          r_g <= '0;
          if (!w_last_c) begin
            r_c <= r_c + 1'b1;
          end else begin
            r_c <= '0;
            r_r <= r_r + 1'b1;
          end
        end
      end
    end
  end

  stream_skid #(
    .DW(PIXEL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_vld_d),
    .i_data  (w_din),
    .i_ready (out_ready),
    .o_valid (data_valid),
    .o_data  (pixel_out),
    .o_count (w_cnt)
  );

endmodule

// File: tb/tb_fmap_streamer.sv
// tb_fmap_streamer: directed beat-order, stall, reset and corner checks.
// Expected beats come from hand-written index tables into the memory model.
`timescale 1ns/1ps
module tb_fmap_streamer;

  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_channels = '0;
  logic [15:0] img_width = '0;
  logic [15:0] img_height = '0;
  logic [31:0] base_addr = '0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [63:0] mem_rd_data = '0;
  logic [63:0] pixel_out;
  logic        data_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int n_err = 0;
  int n_chk = 0;

  logic [63:0] mem [256];
  logic [63:0] got [$];
  logic [63:0] exp_q [$];
  int          idx_q [$];

  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          lat_cnt = 0;
  int          lat_dv = -1;
  int          lat_done = -1;
  bit          lat_run = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_pix = '0;

  always #5 clk = ~clk;

  fmap_streamer #(
    .ADDR_W  (32),
    .MAX_DIM (1024)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_channels (in_channels),
    .img_width   (img_width),
    .img_height  (img_height),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pixel_out   (pixel_out),
    .data_valid  (data_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [63:0] memval(input int i);
    return 64'hF00D_0000_0000_0000 | (64'(i) << 16) | 64'(i + 1);
  endfunction

  // 1-cycle memory; junk when not read so pad beats cannot borrow it
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[8'(mem_rd_addr % 32'd256)];
    else           mem_rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", 64'(data_valid), 64'd1);
        chk("stall_pix", pixel_out, prev_pix);
      end
      if (data_valid && out_ready) got.push_back(pixel_out);
      if (done) done_cnt++;
      if (mem_rd_en) rd_cnt++;
      if (start && !busy) begin
        lat_cnt  = 0;
        lat_run  = 1'b1;
        lat_dv   = -1;
        lat_done = -1;
      end else if (lat_run) begin
        lat_cnt++;
      end
      if (lat_run && data_valid && lat_dv < 0) lat_dv = lat_cnt;
      if (lat_run && done && lat_done < 0) lat_done = lat_cnt;
      prev_stall = data_valid && !out_ready;
      prev_pix   = pixel_out;
    end
  end

  task automatic build(input int base);
    exp_q.delete();
    foreach (idx_q[i])
      exp_q.push_back(idx_q[i] < 0 ? 64'd0 : memval(base + idx_q[i]));
  endtask

  task automatic run(input logic [15:0] w, input logic [15:0] h,
                     input logic [15:0] c, input logic [31:0] base,
                     input bit tog, input bit dup, input string nm);
    int g0, d0, r0, cyc, n_rd;
    g0 = got.size();
    d0 = done_cnt;
    r0 = rd_cnt;
    n_rd = 0;
    foreach (idx_q[i]) if (idx_q[i] >= 0) n_rd++;
    @(posedge clk); #1;
    img_width   = w;
    img_height  = h;
    in_channels = c;
    base_addr   = base;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    img_width   = 16'd5;
    img_height  = 16'd7;
    in_channels = 16'd64;
    base_addr   = 32'd0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin
      if (tog) out_ready = ~out_ready;
      start = (dup && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_timeout"}, 64'(cyc < 400), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_len"}, 64'(got.size() - g0), 64'(exp_q.size()));
    chk({nm, "_rd_cnt"}, 64'(rd_cnt - r0), 64'(n_rd));
    foreach (exp_q[i])
      if (g0 + i < got.size())
        chk($sformatf("%s_b%0d", nm, i), got[g0 + i], exp_q[i]);
    if (exp_q.size() == 0)
      chk({nm, "_done_lat"}, 64'(lat_done), 64'd1);
    else if (!tog)
      chk({nm, "_first_lat"}, 64'(lat_dv >= 0 && lat_dv <= 2), 64'd1);
  endtask

  task automatic reset_mid(input int k, input logic [31:0] base);
    int g0, cyc;
    g0 = got.size();
    @(posedge clk); #1;
    img_width   = 16'd2;
    img_height  = 16'd2;
    in_channels = 16'd8;
    base_addr   = base;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (got.size() - g0 < k && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reach", 64'(got.size() - g0 >= k), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pix", pixel_out, 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = memval(i);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_done", 64'(done), 64'd0);
    chk("init_dv", 64'(data_valid), 64'd0);
    chk("init_rd_en", 64'(mem_rd_en), 64'd0);
    chk("init_pix", pixel_out, 64'd0);
    chk("init_addr", 64'(mem_rd_addr), 64'd0);
    rst_n = 1'b1;

`ifdef FMAP_STREAMER_PAD_EN
    idx_q = '{-1, -1, -1, -1, -1, 0, 1, -1,
              -1, 2, 3, -1, -1, -1, -1, -1};
    build(BASE);
    run(16'd2, 16'd2, 16'd8, BASE, 1'b0, 1'b0, "pad22");
    run(16'd2, 16'd2, 16'd8, BASE, 1'b1, 1'b1, "pad22_tog");
    idx_q = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 1,
              -1, -1, -1, -1, -1, -1, -1, -1};
    build(40);
    run(16'd1, 16'd1, 16'd16, 32'd40, 1'b0, 1'b0, "pad11");
    run(16'd1, 16'd1, 16'd16, 32'd40, 1'b1, 1'b0, "pad11_tog");
    reset_mid(5, BASE);
    idx_q = '{-1, -1, -1, -1, -1, 0, 1, -1,
              -1, 2, 3, -1, -1, -1, -1, -1};
    build(BASE);
    run(16'd2, 16'd2, 16'd8, BASE, 1'b0, 1'b0, "pad22_rst");
`else
    idx_q = '{0, 1, 2, 3};
    build(BASE);
    run(16'd2, 16'd2, 16'd8, BASE, 1'b0, 1'b0, "m22");
    run(16'd2, 16'd2, 16'd8, BASE, 1'b1, 1'b1, "m22_tog");
    idx_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    build(40);
    run(16'd2, 16'd2, 16'd16, 32'd40, 1'b1, 1'b0, "m22g2_tog");
    idx_q = '{0, 1, 2};
    build(BASE);
    run(16'd3, 16'd1, 16'd8, BASE, 1'b0, 1'b0, "m31");
    reset_mid(2, BASE);
    idx_q = '{0, 1, 2, 3};
    build(BASE);
    run(16'd2, 16'd2, 16'd8, BASE, 1'b0, 1'b0, "m22_rst");
`endif

    idx_q.delete();
    build(BASE);
    run(16'd2, 16'd0, 16'd8, BASE, 1'b0, 1'b0, "zero_h");
    run(16'd0, 16'd2, 16'd8, BASE, 1'b0, 1'b0, "zero_w");
    run(16'd2, 16'd2, 16'd4, BASE, 1'b0, 1'b0, "zero_g");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fmap_streamer.md
FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of the word address to feature-map memory.
REQ-002 SHALL have parameter MAX_DIM, default 1024, meaning the maximum img_width and img_height supported.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin streaming one feature map.
REQ-006 SHALL have ports in_channels, img_width and img_height  input  16 each  meaning feature-map geometry in NHWC order.
REQ-007 SHALL have port base_addr  input  ADDR_W  meaning the memory word address of pixel (0,0), channel group 0.
REQ-008 SHALL have ports mem_rd_en (output, 1), mem_rd_addr (output, ADDR_W) and mem_rd_data (input, 64), meaning a memory read port with fixed 1-cycle read latency.
REQ-009 SHALL have ports pixel_out (output, 64), data_valid (output, 1) and out_ready (input, 1), meaning the downstream stream of 8 channels per word.
REQ-010 SHALL have ports busy (output, 1) and done (output, 1), meaning streaming is in progress and a one-cycle completion pulse.

Function
REQ-011 SHALL capture G = in_channels>>3, img_width, img_height and base_addr on the start cycle in IDLE, and SHALL ignore later input changes until done.
REQ-012 SHALL ignore start while busy=1.
REQ-013 SHALL use FSM states IDLE -> RUN -> DRAIN -> IDLE: RUN while beats remain to issue, DRAIN until the last beat transfers, and IDLE after done.
REQ-014 SHALL emit beats in order row-major, then column, then channel group, with the channel group fastest.
REQ-015 SHALL make a padding beat pixel_out=0 without asserting mem_rd_en.
REQ-016 SHALL make an interior pixel (r,c), group g read address base_addr + (r*img_width + c)*G + g, produced by an incrementing counter with no multiplier in the per-beat path.
REQ-017 SHALL count a transfer only when data_valid && out_ready, and SHALL hold pixel_out stable while data_valid && !out_ready.
REQ-018 SHALL NOT drop or duplicate any beat under arbitrary out_ready patterns, using a 2-entry skid for in-flight reads.
REQ-019 SHALL NOT issue a memory read or a padding beat unless a skid slot is guaranteed free.
REQ-020 SHALL assert data_valid for the first beat no later than 2 cycles after the start cycle when out_ready=1.
REQ-021 SHALL sustain 1 beat per cycle when out_ready is held high.
REQ-022 SHALL assert done for exactly one cycle, on the cycle after the final transfer, and SHALL clear busy on that same cycle.
REQ-023 SHALL pulse done one cycle after start, with no data_valid and no mem_rd_en, when G, img_width or img_height is 0.
REQ-024 SHALL keep wrap of all counters internal, with widths covering MAX_DIM+2 columns and rows.

Reset
REQ-025 SHALL on rst_n=0 force IDLE, busy=0, done=0, data_valid=0, mem_rd_en=0, pixel_out=0 and mem_rd_addr=0, and SHALL empty the skid.
REQ-026 SHALL discard any read in flight when reset is asserted mid-stream, and SHALL restart the next start from beat 0.

Configuration
REQ-027 SHALL, with FMAP_STREAMER_PAD_EN defined, surround the map with a 1-pixel zero border, giving (H+2)*(W+2)*G beats in total.
REQ-028 SHALL, without FMAP_STREAMER_PAD_EN, stream only H*W*G memory beats with no padding logic compiled.

Structure
REQ-029 SHALL take PIXEL_W=64 and CH_PER_WORD=8 from the shared package yolo_pkg, together with the typedef for the streamer state enum.
REQ-030 SHALL instantiate exactly one sub-module, stream_skid (2-entry, 64-bit, valid/ready).

Verification
REQ-031 SHALL cover: PAD_EN, W=2, H=2, C=8, out_ready=1 -> 16 beats 0,0,0,0, 0,m0,m1,0, 0,m2,m3,0, 0,0,0,0 (mN = mem[base+N]), then one done pulse.
REQ-032 SHALL cover: PAD_EN, W=1, H=1, C=16 -> 18 beats, where beats 8 and 9 are mem[base] and mem[base+1] and all others are 0.
REQ-033 SHALL cover: out_ready toggling 1,0,1,0 during scenario REQ-031 -> an identical 16-beat sequence, with pixel_out stable on every stalled cycle.
REQ-034 SHALL cover: rst_n=0 after 5 transfers -> the next cycle shows data_valid=0, busy=0, mem_rd_en=0, and a new start reproduces beat 0.
REQ-035 SHALL cover: start with img_height=0 -> done pulse 1 cycle later and no data_valid; a start pulse during busy -> no effect on the sequence.
REQ-036 SHALL cover: PAD_EN undefined, W=2, H=2, C=8 -> exactly 4 beats m0, m1, m2, m3, then done.
